adder_stim_gen: RTL and testbench

ADDER_STIM_GEN -- requirements
Module: adder_stim_gen

---
 rtl/adder_stim_gen_pkg.sv | 36 +++
 rtl/adder_stim_gen_if.sv | 29 ++
 rtl/adder_stim_gen_lfsr32.sv | 35 +++
 rtl/adder_stim_gen.sv | 149 ++++++++++++++
 tb/tb_adder_stim_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_stim_gen_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : adder_stim_gen_pkg                                         |
// | Function : Shared types and constants for the adder stimulus          |
// |            generator: FSM states, stimulus modes, LFSR constants.     |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package adder_stim_gen_pkg;

  // Generator control states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GEN     = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Stimulus classes selected by the mode input
  localparam logic [1:0] c_MODE_RANDOM    = 2'd0;
  localparam logic [1:0] c_MODE_PROPAGATE = 2'd1;
  localparam logic [1:0] c_MODE_WALK      = 2'd2;
  localparam logic [1:0] c_MODE_EXTREME   = 2'd3;

  // Right-shift Galois feedback mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] c_LFSR_POLY  = 32'h8020_0003;

  // An all-zero LFSR would lock up, so a zero seed is replaced by this
  localparam logic [31:0] c_SEED_SUBST = 32'h0000_0001;

  // One Galois step: shift right, fold the polynomial in when bit 0 drops out
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? c_LFSR_POLY : 32'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_stim_gen_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : adder_stim_gen_if                                          |
// | Function : Vector handshake bus between the stimulus generator and    |
// |            the consumer (adder under test plus comparator).           |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
interface adder_stim_gen_if #(
  parameter int n = 128
);
  logic         valid;
  logic         ready;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         cin;
  logic [31:0]  vec_count;
  logic         done;

  modport master (
    output valid, a, b, cin, vec_count, done,
    input  ready
  );

  modport slave (
    input  valid, a, b, cin, vec_count, done,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/adder_stim_gen_lfsr32.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : adder_lfsr32                                               |
// | Function : 32-bit Galois LFSR with synchronous seed load and step     |
// |            enable; zero seeds are replaced by a nonzero value.        |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module adder_lfsr32
  import adder_stim_gen_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        load,
  input  wire logic [31:0] seed,
  input  wire logic        step,
  output logic      [31:0] state
);

  logic [31:0] r_state;

  // Load wins over step so a new run always starts from the given seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_SEED_SUBST;
    end else if (load) begin
      r_state <= (seed == 32'h0) ? c_SEED_SUBST : seed;
    end else if (step) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/adder_stim_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : adder_stim_gen                                             |
// | Function : Generates operand vectors (a, b, cin) for an n-bit adder   |
// |            from a 32-bit LFSR, one 32-bit word per GEN cycle, and     |
// |            presents them on a valid/ready bus.                        |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module adder_stim_gen
  import adder_stim_gen_pkg::*;
#(
  parameter int n         = 128,   // operand width, multiple of 32; must match bus.n
  parameter int file_size = 30000  // vectors per run
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  input  wire logic [1:0]  mode,
  input  wire logic [31:0] seed,
  adder_stim_gen_if.master bus
);

  localparam int          c_NWORDS    = n / 32;
  localparam int          c_GEN_LAST  = 2 * c_NWORDS;           // index of the cin word
  localparam int          c_IDX_W     = $clog2(c_GEN_LAST + 1);
  localparam int          c_WALK_W    = $clog2(n);
  localparam logic [31:0] c_FILE_SIZE = 32'(file_size);

  state_t              r_state;
  state_t              w_next;
  logic [c_IDX_W-1:0]  r_idx;
  logic [1:0]          r_mode;
  logic [n-1:0]        r_a;
  logic [n-1:0]        r_b;
  logic                r_cin;
  logic [31:0]         r_count;
  logic [c_WALK_W-1:0] r_walk;     // vec_count mod n, kept incrementally
  logic [31:0]         w_lfsr;
  logic                w_load;
  logic                w_gen;
  logic                w_gen_last;
  logic                w_accept;
  logic [31:0]         w_count_inc;
  logic [n-1:0]        w_walk_bit;

  assign w_gen       = (r_state == ST_GEN);
  assign w_gen_last  = w_gen && (r_idx == c_IDX_W'(c_GEN_LAST));
  assign w_accept    = (r_state == ST_PRESENT) && bus.ready;
  assign w_count_inc = (r_count == 32'hFFFF_FFFF) ? r_count : r_count + 32'd1;
  assign w_walk_bit  = {{(n-1){1'b0}}, 1'b1} << r_walk;

  adder_lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .seed  (seed),
    .step  (w_gen),
    .state (w_lfsr)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; start is only honoured from IDLE or DONE
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_next = ST_GEN;
          w_load = 1'b1;
        end
      end
      ST_GEN: begin
        if (w_gen_last) w_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.ready) w_next = (w_count_inc == c_FILE_SIZE) ? ST_DONE : ST_GEN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Vector assembly: LFSR words fill a then b LSW first, last word gives cin;
  // the non-random modes overwrite the result on the final GEN cycle so every
  // mode spends the same number of cycles and LFSR steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_mode  <= c_MODE_RANDOM;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_count <= '0;
      r_walk  <= '0;
    end else if (w_load) begin
      r_idx   <= '0;
      r_mode  <= mode;
      r_count <= '0;
      r_walk  <= '0;
    end else if (w_gen) begin
      r_idx <= w_gen_last ? '0 : r_idx + c_IDX_W'(1);
      for (int w = 0; w < c_NWORDS; w++) begin
        if (r_idx == c_IDX_W'(w))            r_a[w*32 +: 32] <= w_lfsr;
        if (r_idx == c_IDX_W'(c_NWORDS + w)) r_b[w*32 +: 32] <= w_lfsr;
      end
      if (w_gen_last) begin
        case (r_mode)
          c_MODE_PROPAGATE: begin
            r_b   <= ~r_a;
            r_cin <= 1'b1;
          end
          c_MODE_WALK: begin
            r_a   <= '1;
            r_b   <= w_walk_bit;
            r_cin <= 1'b0;
          end
          c_MODE_EXTREME: begin
            r_a   <= {n{r_count[0]}};
            r_b   <= {n{r_count[0]}};
            r_cin <= r_count[0];
          end
          default: r_cin <= w_lfsr[0];
        endcase
      end
    end else if (w_accept) begin
      r_count <= w_count_inc;
      if (r_count != 32'hFFFF_FFFF) begin
        r_walk <= (r_walk == c_WALK_W'(n - 1)) ? '0 : r_walk + c_WALK_W'(1);
      end
    end
  end

  assign bus.valid     = (r_state == ST_PRESENT);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.cin       = r_cin;
  assign bus.vec_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_adder_stim_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_adder_stim_gen                                          |
// | Function : Self-checking bench for adder_stim_gen against a           |
// |            behavioural vector model.                                  |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_adder_stim_gen;

  localparam int N   = 128;
  localparam int W   = N / 32;
  localparam int FS0 = 300;
  localparam int FS1 = 4;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
  } vec_t;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] seed;
    int          nvec;
    bit          rnd;
    int          exp_count;
  } run_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic [1:0]  mode0, mode1;
  logic [31:0] seed0, seed1;

  int n_checks = 0;
  int n_fail   = 0;

  // model state for dut0
  logic [31:0] m_lf;
  logic [1:0]  m_mode;
  int unsigned m_k;

  always #5 clk = ~clk;

  adder_stim_gen_if #(.n(N)) bus0 ();
  adder_stim_gen_if #(.n(N)) bus1 ();

  adder_stim_gen #(.n(N), .file_size(FS0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .seed(seed0), .bus(bus0.master)
  );

  adder_stim_gen #(.n(N), .file_size(FS1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .seed(seed1), .bus(bus1.master)
  );

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for valid, got 0, expected 1", name);
  endtask

  // Galois LFSR step built from the exponent list of the polynomial
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    int          exps [4] = '{32, 22, 2, 1};
    logic [31:0] mask = '0;
    foreach (exps[i]) mask[exps[i]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  function automatic logic [31:0] ref_adv(input logic [31:0] lf);
    logic [31:0] s = lf;
    for (int i = 0; i < 2*W+1; i++) s = ref_step(s);
    return s;
  endfunction

  // Vector k of a run whose LFSR stands at lf when its GEN phase starts
  function automatic vec_t ref_vec(input logic [1:0] md, input int unsigned k, input logic [31:0] lf);
    vec_t        v;
    logic [31:0] wd [2*W+1];
    logic [31:0] s = lf;
    for (int i = 0; i < 2*W+1; i++) begin
      wd[i] = s;
      s = ref_step(s);
    end
    v.a = '0;
    v.b = '0;
    for (int i = 0; i < W; i++) begin
      v.a[32*i +: 32] = wd[i];
      v.b[32*i +: 32] = wd[W+i];
    end
    v.cin = wd[2*W][0];
    case (md)
      2'd1: begin v.b = ~v.a; v.cin = 1'b1; end
      2'd2: begin v.a = '1; v.b = '0; v.b[k % N] = 1'b1; v.cin = 1'b0; end
      2'd3: begin
        if (k % 2 == 1) begin v.a = '1; v.b = '1; v.cin = 1'b1; end
        else            begin v.a = '0; v.b = '0; v.cin = 1'b0; end
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    start0     = 1'b0;
    start1     = 1'b0;
    bus0.ready = 1'b0;
    bus1.ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulse start on dut0 and re-seed the model; inputs are scrambled after
  // the pulse so only the sampled values can matter.
  task automatic start_run(input logic [1:0] md, input logic [31:0] sd);
    mode0  = md;
    seed0  = sd;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    mode0  = 2'($urandom);
    seed0  = $urandom;
    m_mode = md;
    m_lf   = (sd == 32'h0) ? 32'h1 : sd;
    m_k    = 0;
  endtask

  // Collect nvec vectors from dut0, comparing each with the model and
  // checking that a held vector does not change while ready is low.
  task automatic get_vectors(input int nvec, input bit rnd, input string tag);
    int   got  = 0;
    int   idle = 0;
    bit   seen = 0;
    vec_t exp;
    while (got < nvec) begin
      if (bus0.valid) begin
        if (!seen) begin
          exp  = ref_vec(m_mode, m_k, m_lf);
          m_lf = ref_adv(m_lf);
          check($sformatf("%s v%0d a", tag, m_k), bus0.a, exp.a);
          check($sformatf("%s v%0d b", tag, m_k), bus0.b, exp.b);
          check($sformatf("%s v%0d cin", tag, m_k), N'(bus0.cin), N'(exp.cin));
          seen = 1;
        end else begin
          check($sformatf("%s v%0d hold", tag, m_k), bus0.a ^ bus0.b, exp.a ^ exp.b);
        end
        bus0.ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        idle = 0;
        if (bus0.ready) begin
          got++;
          m_k++;
          seen = 0;
        end
      end else begin
        bus0.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        idle++;
        if (idle > 40) begin
          timeout_fail(tag);
          break;
        end
      end
      @(negedge clk);
    end
    bus0.ready = 1'b0;
  endtask

  task automatic wait_valid0(input string tag);
    int c = 0;
    while (!bus0.valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (!bus0.valid) timeout_fail(tag);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin : main
    run_t        runs [6];
    int          lat;
    int          k1;
    bit          bad;
    logic [31:0] lf1;
    vec_t        e1;

    runs[0] = '{2'd0, 32'hDEADBEEF, 3, 1'b0, 3};
    runs[1] = '{2'd1, 32'h12345678, 3, 1'b1, 3};
    runs[2] = '{2'd3, 32'hA5A5A5A5, 4, 1'b0, 4};
    runs[3] = '{2'd2, 32'h00000001, 5, 1'b1, 5};
    runs[4] = '{2'd0, 32'hFFFFFFFF, 2, 1'b1, 2};
    runs[5] = '{2'd3, 32'h00000000, 3, 1'b1, 3};

    mode0 = 2'd0; seed0 = 32'h0; mode1 = 2'd0; seed1 = 32'h0;

    // Reset values and staying in IDLE afterwards
    do_reset();
    check("rst valid", N'(bus0.valid), N'(0));
    check("rst done", N'(bus0.done), N'(0));
    check("rst vec_count", N'(bus0.vec_count), N'(0));
    check("rst a", bus0.a, '0);
    check("rst b", bus0.b, '0);
    check("rst cin", N'(bus0.cin), N'(0));
    repeat (5) @(negedge clk);
    check("idle no valid", N'(bus0.valid | bus0.done), N'(0));

    // Zero seed: LFSR loads 1, first valid 9 cycles after GEN entry
    start_run(2'd0, 32'h0);
    check("seed0 lfsr", N'(dut0.u_lfsr.state), N'(32'h1));
    lat = 0;
    while (!bus0.valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("first latency", N'(lat), N'(2*W+1));
    get_vectors(3, 1'b0, "seed0");
    check("seed0 vec_count", N'(bus0.vec_count), N'(3));

    // Table of runs
    for (int r = 0; r < 6; r++) begin
      do_reset();
      start_run(runs[r].mode, runs[r].seed);
      get_vectors(runs[r].nvec, runs[r].rnd, $sformatf("tbl%0d", r));
      check($sformatf("tbl%0d vec_count", r), N'(bus0.vec_count), N'(runs[r].exp_count));
    end

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      do_reset();
      start_run(2'($urandom), $urandom);
      get_vectors(int'($urandom_range(1, 4)), 1'b1, $sformatf("rnd%0d", r));
    end

    // Walking carry through the wrap at vector n
    do_reset();
    start_run(2'd2, 32'h55);
    get_vectors(N, 1'b0, "walk");
    wait_valid0("walk wrap");
    check("walk wrap b", bus0.b, N'(1));
    check("walk wrap a", bus0.a, '1);
    get_vectors(2, 1'b0, "walk2");

    // Extremes held with ready low for 20 cycles
    do_reset();
    start_run(2'd3, 32'h7);
    wait_valid0("hold");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.valid !== 1'b1 || bus0.a !== '0 || bus0.b !== '0 || bus0.cin !== 1'b0) bad = 1;
    end
    check("hold stable", N'(bad), N'(0));
    check("hold valid", N'(bus0.valid), N'(1));
    bus0.ready = 1'b1;
    @(negedge clk);
    bus0.ready = 1'b0;
    check("hold vec_count", N'(bus0.vec_count), N'(1));

    // Asynchronous reset during PRESENT, then the same sequence again
    do_reset();
    start_run(2'd0, 32'h00C0FFEE);
    get_vectors(2, 1'b0, "pre");
    wait_valid0("arst");
    #2 rst_n = 1'b0;
    #1;
    check("arst valid", N'(bus0.valid), N'(0));
    check("arst a", bus0.a, '0);
    check("arst b", bus0.b, '0);
    check("arst cin", N'(bus0.cin), N'(0));
    check("arst vec_count", N'(bus0.vec_count), N'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(2'd0, 32'h00C0FFEE);
    get_vectors(3, 1'b0, "post");

    // Start pulsed during GEN is ignored
    do_reset();
    start_run(2'd1, 32'h2468ACE0);
    repeat (3) @(negedge clk);
    mode0  = 2'd2;
    seed0  = 32'd99;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    get_vectors(3, 1'b1, "genstart");
    check("genstart vec_count", N'(bus0.vec_count), N'(3));

    // Short run to DONE on the file_size = 4 instance
    do_reset();
    mode1  = 2'd1;
    seed1  = 32'h0000BEEF;
    start1 = 1'b1;
    @(negedge clk);
    start1     = 1'b0;
    bus1.ready = 1'b1;
    lf1 = 32'h0000BEEF;
    k1  = 0;
    e1  = '0;
    for (int i = 0; i < 100 && !bus1.done; i++) begin
      if (bus1.valid) begin
        e1  = ref_vec(2'd1, k1, lf1);
        lf1 = ref_adv(lf1);
        check($sformatf("fs4 v%0d a", k1), bus1.a, e1.a);
        check($sformatf("fs4 v%0d b=~a", k1), bus1.b, ~bus1.a);
        check($sformatf("fs4 v%0d cin", k1), N'(bus1.cin), N'(1));
        k1++;
      end
      @(negedge clk);
    end
    check("fs4 vectors", N'(k1), N'(FS1));
    check("fs4 done", N'(bus1.done), N'(1));
    check("fs4 valid", N'(bus1.valid), N'(0));
    check("fs4 vec_count", N'(bus1.vec_count), N'(FS1));
    repeat (3) @(negedge clk);
    check("fs4 hold a", bus1.a, e1.a);
    check("fs4 hold count", N'(bus1.vec_count), N'(FS1));
    bus1.ready = 1'b0;
    start1     = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("fs4 restart done", N'(bus1.done), N'(0));
    check("fs4 restart count", N'(bus1.vec_count), N'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
